aes_inv_cipher: RTL and testbench

AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

---
 rtl/aes_inv_cipher_pkg.sv | 66 ++++++
 rtl/aes_inv_cipher_sbox.sv | 29 ++
 rtl/aes_inv_cipher.sv | 94 +++++++++
 tb/tb_aes_inv_cipher.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_cipher_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 inverse cipher.
// Byte (r,c) of a state lives at bits [127-8*(4r+c) -: 8] (row-major).
package aes_inv_cipher_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_e;

  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(4*r+c) -: 8] = s[127-8*(4*r+((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // col[31:24] is row 0 of the column.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic aes_state_t inv_mix_columns(input aes_state_t s);
    aes_state_t  o;
    logic [31:0] col;
    o   = '0;
    col = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) col[31-8*r -: 8] = s[127-8*(4*r+c) -: 8];
      col = inv_mix_column(col);
      for (int r = 0; r < 4; r++) o[127-8*(4*r+c) -: 8] = col[31-8*r -: 8];
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_sbox.sv
// AES inverse S-box: purely combinational 256-entry lookup.
module aes_inv_sbox (
  input  logic [7:0] b_i,
  output logic [7:0] b_o
);

  // Entry 0 sits in the top byte; entry x at [2047-8x -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign b_o = INV_SBOX[11'd2047 - {b_i, 3'b000} -: 8];

endmodule

// File: rtl/aes_inv_cipher.sv
// AES-128 inverse cipher, one round per clock, round keys fetched by key_idx.
// Optional macro AES_DEC_ABORT_EN adds an abort input that drops the block in flight.
module aes_inv_cipher
  import aes_inv_cipher_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
`ifdef AES_DEC_ABORT_EN
  input  logic         abort,
`endif
  output logic         in_ready,
  input  logic [127:0] ct_in,
  output logic [3:0]   key_idx,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt_out
);

  fsm_e       state_q, state_d;
  aes_state_t data_q, data_d;
  logic [3:0] cnt_q, cnt_d;
  aes_state_t shifted, subbed, sub_key, mixed;

  assign shifted = inv_shift_rows(data_q);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .b_i(shifted[127-8*g -: 8]),
      .b_o(subbed[127-8*g -: 8])
    );
  end

  assign sub_key = subbed ^ key_in;
  assign mixed   = inv_mix_columns(sub_key);
  assign pt_out  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    key_idx   = 4'd0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        key_idx  = 4'(AES_NR);
        if (in_valid) begin
          data_d  = ct_in ^ key_in;
          cnt_d   = 4'(AES_NR - 1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        key_idx = cnt_q;
        data_d  = mixed;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = FINAL;
      end
      FINAL: begin
        data_d  = sub_key;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef AES_DEC_ABORT_EN
    // Abort freezes the datapath and drops back to IDLE without presenting output.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      data_d  = data_q;
      cnt_d   = cnt_q;
    end
`endif
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: random plaintexts are encrypted by a forward-AES model,
// the DUT must recover them; a per-cycle timeline model checks the handshake outputs.
`timescale 1ns/1ps
module tb_aes_inv_cipher;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct_in;
  logic [3:0]   key_idx;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt_out;
`ifdef AES_DEC_ABORT_EN
  logic         abort;
`endif

  logic [127:0] rk_f  [0:10];   // round keys, FIPS byte order
  logic [127:0] rk_rm [0:10];   // round keys, row-major as the key file serves them
  logic [7:0]   sbox  [0:255];
  logic [127:0] cur_pt;
  bit           rand_rdy = 1'b0;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  assign key_in = (key_idx <= 4'd10) ? rk_rm[key_idx] : 128'h0;

  aes_inv_cipher dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
`ifdef AES_DEC_ABORT_EN
    .abort(abort),
`endif
    .in_ready(in_ready), .ct_in(ct_in), .key_idx(key_idx), .key_in(key_in),
    .out_valid(out_valid), .out_ready(out_ready), .pt_out(pt_out)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Polynomial product followed by reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h11B << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, bb;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      bb = inv;
      sbox[x] = bb ^ {bb[6:0], bb[7]} ^ {bb[5:0], bb[7:6]} ^ {bb[4:0], bb[7:5]}
              ^ {bb[3:0], bb[7:4]} ^ 8'h63;
    end
  endtask

  // FIPS order: byte index r+4c; row-major: byte index 4r+c.
  function automatic logic [127:0] to_rm(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*r+c) -: 8] = v[127-8*(r+4*c) -: 8];
    return o;
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) begin
      rk_f[r]  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      rk_rm[r] = to_rm(rk_f[r]);
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127-8*(r+4*c) -: 8] ^ rk_f[0][127-8*(r+4*c) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[0][c] = mul(8'h02, t[0][c]) ^ mul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ mul(8'h02, t[1][c]) ^ mul(8'h03, t[2][c]) ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ mul(8'h02, t[2][c]) ^ mul(8'h03, t[3][c]);
          s[3][c] = mul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ mul(8'h02, t[3][c]);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = s[r][c] ^ rk_f[rnd][127-8*(r+4*c) -: 8];
    end
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[r][c];
    return o;
  endfunction

  // Timeline model: phase 0 = idle, phase n = n edges since the accepting edge
  // (the accepting edge counts as 1); plaintext is due at phase 11.
  int           phase = 0;
  logic [127:0] exp_rm = '0;
  logic [3:0]   exp_kid;

  always @(negedge clk) begin
    if (rst) begin
      phase = 0;
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_key_idx", 128'(key_idx), 128'(10));
      chk("rst_pt_out", pt_out, 128'h0);
    end else begin
      if (phase == 0) exp_kid = 4'd10;
      else if (phase <= 9) exp_kid = 4'(10 - phase);
      else exp_kid = 4'd0;
      chk("in_ready", 128'(in_ready), 128'(phase == 0));
      chk("out_valid", 128'(out_valid), 128'(phase == 11));
      chk("key_idx", 128'(key_idx), 128'(exp_kid));
      if (phase == 11) chk("pt_out", pt_out, exp_rm);
`ifdef AES_DEC_ABORT_EN
      if (phase != 0 && abort) phase = 0; else
`endif
      if (phase == 0) begin
        if (in_valid) begin
          phase  = 1;
          exp_rm = to_rm(cur_pt);
        end
      end else if (phase == 11) begin
        if (out_ready) phase = 0;
      end else begin
        phase++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [127:0] pt, input bit hold);
    int n;
    n = 0;
    cur_pt   = pt;
    ct_in    = to_rm(aes_enc(pt));
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("accept_wait", 128'(n < 100), 128'(1));
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_hs();
    int n;
    n = 0;
    while (!(out_valid && out_ready) && n < 300) begin tick(); n++; end
    chk("handshake_wait", 128'(n < 300), 128'(1));
    tick();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int           n;
    logic [127:0] snap;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ct_in     = '0;
    cur_pt    = '0;
`ifdef AES_DEC_ABORT_EN
    abort     = 1'b0;
`endif
    build_sbox();
    chk("model_mul_57_83", 128'(mul(8'h57, 8'h83)), 128'(8'hc1));
    chk("model_sbox_00", 128'(sbox[0]), 128'(8'h63));
    chk("model_sbox_53", 128'(sbox[8'h53]), 128'(8'hed));
    set_key(128'h000102030405060708090a0b0c0d0e0f);
    chk("model_fips_ct", aes_enc(128'h00112233445566778899aabbccddeeff),
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    repeat (3) @(posedge clk);
    #1;

    // FIPS-197 C.1, accepted on the first edge after reset release
    cur_pt   = 128'h00112233445566778899aabbccddeeff;
    ct_in    = to_rm(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    in_valid = 1'b1;
    rst      = 1'b0;
    chk("fips_in_ready", 128'(in_ready), 128'(1));
    chk("kidx_trace_0", 128'(key_idx), 128'(10));
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 30) begin
      chk("kidx_trace", 128'(key_idx), 128'(n <= 9 ? 10 - n : 0));
      tick();
      n++;
    end
    chk("fips_latency", 128'(n), 128'(11));
    chk("fips_pt", pt_out, to_rm(128'h00112233445566778899aabbccddeeff));
    chk("done_key_idx", 128'(key_idx), 128'(0));
    tick();

    // Output stall with ignored in_valid pulses
    out_ready = 1'b0;
    send(rnd128(), 1'b0);
    n = 0;
    while (!out_valid && n < 30) begin tick(); n++; end
    chk("stall_reach_done", 128'(out_valid), 128'(1));
    snap = pt_out;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      ct_in    = rnd128();
      tick();
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      chk("stall_pt_stable", pt_out, snap);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send(rnd128(), 1'b0);
    wait_hs();

    // Reset in the middle of the round sequence
    send(rnd128(), 1'b0);
    n = 0;
    while (key_idx != 4'd5 && n < 30) begin tick(); n++; end
    chk("reach_round5", 128'(key_idx), 128'(5));
    #2 rst = 1'b1;
    #1;
    chk("rst_now_in_ready", 128'(in_ready), 128'(1));
    chk("rst_now_out_valid", 128'(out_valid), 128'(0));
    chk("rst_now_key_idx", 128'(key_idx), 128'(10));
    chk("rst_now_pt_out", pt_out, 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(rnd128(), 1'b0);
    wait_hs();

    // Back-to-back with in_valid held high
    send(rnd128(), 1'b1);
    cur_pt = rnd128();
    ct_in  = to_rm(aes_enc(cur_pt));
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    chk("b2b_next_accept", 128'(n), 128'(11));
    tick();
    in_valid = 1'b0;
    wait_hs();

    // Random blocks, random gaps, random output back-pressure, fresh keys
    rand_rdy = 1'b1;
    for (int b = 0; b < 16; b++) begin
      if (b % 4 == 0) set_key(rnd128());
      repeat ($urandom_range(0, 2)) tick();
      send(rnd128(), 1'b0);
      wait_hs();
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;

`ifdef AES_DEC_ABORT_EN
    // Abort in FINAL, then abort held in IDLE during an acceptance
    send(rnd128(), 1'b0);
    n = 0;
    while (!(key_idx == 4'd0 && !out_valid && !in_ready) && n < 30) begin tick(); n++; end
    chk("reach_final", 128'(n < 30), 128'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_final_idle", 128'(in_ready), 128'(1));
    chk("abort_final_no_valid", 128'(out_valid), 128'(0));
    tick();
    chk("abort_final_still_no_valid", 128'(out_valid), 128'(0));
    abort = 1'b1;
    send(rnd128(), 1'b0);
    abort = 1'b0;
    chk("abort_idle_accepted", 128'(in_ready), 128'(0));
    wait_hs();
`endif

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
